// File: rtl/tlul_mem_responder.sv
// TL-UL slave endpoint: terminates Channel A Get/PutFullData/PutPartialData in a small
// register-file memory and returns Channel D responses through a short response queue.
module tlul_mem_responder #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    SRC_WIDTH    = 2,
  parameter int                    SINK_WIDTH   = 1,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000,
  parameter int                    MEM_WORDS    = 16,
  parameter int                    RSP_DEPTH    = 2
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0]   SPAN        = ADDR_WIDTH'(4 * MEM_WORDS);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK      = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA = OPCODE_WIDTH'(1);

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [SIZE_WIDTH-1:0]   size;
    logic [SRC_WIDTH-1:0]    source;
    logic [DATA_WIDTH-1:0]   data;
    logic                    error;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  rsp_t                  rsp_q [RSP_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;

  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic                  is_get, is_put, in_range, misaligned, bad_full, req_error;
  logic                  a_fire, pop, do_write;
  rsp_t                  rsp_new;
  logic                  unused_param;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_param = ^a_param;

  // Request decode: word index and the full set of rejection conditions.
  assign offset   = a_address - BASE_ADDR;
  assign idx      = offset[IDX_W+1:2];
  assign is_get   = (a_opcode == OP_GET);
  assign is_put   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
  assign in_range = (a_address >= BASE_ADDR) && (offset < SPAN);
  assign bad_full = (a_opcode == OP_PUT_FULL) &&
                    ((a_size != SIZE_WIDTH'(2)) || (a_mask != '1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    misaligned = 1'b0;
    case (a_size)
      SIZE_WIDTH'(1): misaligned = a_address[0];
      SIZE_WIDTH'(2): misaligned = |a_address[1:0];
      default:        misaligned = 1'b0;
    endcase
  end

  assign req_error = !(is_get || is_put) || !in_range || (a_size > SIZE_WIDTH'(2)) ||
                     misaligned || bad_full;

  assign a_ready  = (count < CNT_W'(RSP_DEPTH));
  assign d_valid  = (count != '0);
  assign a_fire   = a_valid && a_ready;
  assign pop      = d_valid && d_ready;
  assign do_write = a_fire && is_put && !req_error;

  always_comb begin
    rsp_new        = '0;
    rsp_new.opcode = is_get ? OP_ACK_DATA : OP_ACK;
    rsp_new.size   = a_size;
    rsp_new.source = a_source;
    rsp_new.error  = req_error;
    // Read data is the pre-write word, sampled in the accept cycle.
    rsp_new.data   = (is_get && !req_error) ? mem[idx] : '0;
  end

  // NOTE: the memory array is cleared on reset because the block must read back zero
  // after reset; this forces flops rather than a RAM macro, acceptable at this size.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (a_mask[b]) mem[idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) rsp_q[i] <= '0;
    end else begin
      if (a_fire) begin
        rsp_q[wr_ptr] <= rsp_new;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({a_fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Channel D is driven straight from the head entry, so it holds under back-pressure.
  assign d_opcode = rsp_q[rd_ptr].opcode;
  assign d_size   = rsp_q[rd_ptr].size;
  assign d_source = rsp_q[rd_ptr].source;
  assign d_data   = rsp_q[rd_ptr].data;
  assign d_error  = rsp_q[rd_ptr].error;
  assign d_param  = '0;
  assign d_sink   = '0;

endmodule

// File: tb/tb_tlul_mem_responder.sv
// Scoreboard bench for tlul_mem_responder: directed requests push expected responses,
// an independent Channel D monitor pops and compares them in order.
module tb_tlul_mem_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [2:0]  PUT_FULL = 3'd0, PUT_PART = 3'd1, GET = 3'd4;
  localparam logic [2:0]  ACK = 3'd0, ACK_D = 3'd1;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param, d_size;
  logic [1:0]  d_source;
  logic [0:0]  d_sink;
  logic [31:0] d_data;
  logic        d_error;

  tlul_mem_responder dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .d_error(d_error)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [1:0]  source;
    logic        sink;
    logic [31:0] data;
    logic        error;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_got, mon_exp;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a response is consumed on the next rising edge whenever d_valid && d_ready.
  always @(negedge clk_in) begin
    if (!reset_in && d_valid && d_ready) begin
      mon_got = '{opcode: d_opcode, param: d_param, size: d_size, source: d_source,
                  sink: d_sink, data: d_data, error: d_error};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_rsp: got %h with no response outstanding", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("d_rsp", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                      input logic [2:0] e_op, input logic [31:0] e_data, input logic e_err,
                      output int stalls);
    rsp_t e;
    stalls    = 0;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    @(negedge clk_in);
    while (!a_ready && stalls < 100) begin
      stalls++;
      @(negedge clk_in);
    end
    if (!a_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: a_ready %b after %0d cycles, required 1", a_ready, stalls);
      a_valid = 1'b0;
      return;
    end
    e = '{opcode: e_op, param: 3'd0, size: size, source: src, sink: 1'b0,
          data: e_data, error: e_err};
    exp_q.push_back(e);
    @(posedge clk_in);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || d_valid) && t < 500) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 500) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: %0d responses still outstanding, required 0", exp_q.size());
    end
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    int st, total;
    logic [40:0] hold;

    reset_in = 1'b1;  a_valid = 1'b0;  a_opcode = '0;  a_param = 3'd5;  a_size = '0;
    a_source = '0;    a_address = '0;  a_mask = '0;    a_data = '0;     d_ready = 1'b1;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_a_ready",  a_ready,  1);
    check("rst_d_valid",  d_valid,  0);
    check("rst_d_opcode", d_opcode, 0);
    check("rst_d_size",   d_size,   0);
    check("rst_d_source", d_source, 0);
    check("rst_d_data",   d_data,   0);
    check("rst_d_error",  d_error,  0);
    reset_in = 1'b0;
    @(posedge clk_in);
    #1;

    // Reset contents and 1-cycle latency.
    send(GET, 3'd2, 2'd2, BASE + 32'h8, 4'hF, 32'h0, ACK_D, 32'h0, 1'b0, st);
    @(negedge clk_in);
    check("latency_d_valid", d_valid, 1);
    drain();

    // Byte-masked partial write.
    send(PUT_FULL, 3'd2, 2'd0, BASE + 32'h4, 4'hF, 32'hDEAD_BEEF, ACK, 32'h0, 1'b0, st);
    send(PUT_PART, 3'd2, 2'd1, BASE + 32'h4, 4'b0010, 32'h0000_5500, ACK, 32'h0, 1'b0, st);
    send(GET, 3'd2, 2'd3, BASE + 32'h4, 4'h0, 32'h0, ACK_D, 32'hDEAD_55EF, 1'b0, st);

    // Error cases around a known mem[0], plus the last valid word.
    send(PUT_FULL, 3'd2, 2'd0, BASE, 4'hF, 32'h1234_5678, ACK, 32'h0, 1'b0, st);
    send(GET, 3'd2, 2'd1, BASE + 32'h40, 4'hF, 32'h0, ACK_D, 32'h0, 1'b1, st);
    send(GET, 3'd2, 2'd2, BASE - 32'h4, 4'hF, 32'h0, ACK_D, 32'h0, 1'b1, st);
    send(PUT_FULL, 3'd2, 2'd3, BASE + 32'h2, 4'hF, 32'hFFFF_FFFF, ACK, 32'h0, 1'b1, st);
    send(3'd3, 3'd2, 2'd0, BASE, 4'hF, 32'hFFFF_FFFF, ACK, 32'h0, 1'b1, st);
    send(PUT_FULL, 3'd2, 2'd1, BASE, 4'h7, 32'hFFFF_FFFF, ACK, 32'h0, 1'b1, st);
    send(GET, 3'd3, 2'd2, BASE, 4'hF, 32'h0, ACK_D, 32'h0, 1'b1, st);
    send(PUT_PART, 3'd1, 2'd3, BASE + 32'h1, 4'b0010, 32'hFFFF_FFFF, ACK, 32'h0, 1'b1, st);
    send(GET, 3'd2, 2'd0, BASE, 4'hF, 32'h0, ACK_D, 32'h1234_5678, 1'b0, st);
    send(PUT_PART, 3'd0, 2'd1, BASE + 32'h3D, 4'b0010, 32'h0000_AB00, ACK, 32'h0, 1'b0, st);
    send(GET, 3'd2, 2'd2, BASE + 32'h3C, 4'hF, 32'h0, ACK_D, 32'h0000_AB00, 1'b0, st);
    drain();

    // Back-pressure: two fill the queue, the third waits until a pop.
    d_ready = 1'b0;
    send(GET, 3'd2, 2'd0, BASE,         4'hF, 32'h0, ACK_D, 32'h1234_5678, 1'b0, st);
    send(GET, 3'd2, 2'd1, BASE + 32'h4, 4'hF, 32'h0, ACK_D, 32'hDEAD_55EF, 1'b0, st);
    a_valid = 1'b1;  a_opcode = GET;  a_size = 3'd2;  a_source = 2'd2;
    a_address = BASE + 32'h8;  a_mask = 4'hF;
    @(negedge clk_in);
    check("full_a_ready",  a_ready,  0);
    check("full_d_valid",  d_valid,  1);
    check("full_head_src", d_source, 0);
    check("full_head_dat", d_data,   32'h1234_5678);
    hold = {d_opcode, d_size, d_source, d_data, d_error};
    repeat (3) begin
      @(negedge clk_in);
      check("hold_stable", {d_valid, d_opcode, d_size, d_source, d_data, d_error}, {1'b1, hold});
    end
    @(posedge clk_in);
    #1;
    d_ready = 1'b1;
    @(negedge clk_in);
    check("no_comb_ready", a_ready, 0);
    @(negedge clk_in);
    check("ready_after_pop", a_ready, 1);
    exp_q.push_back('{opcode: ACK_D, param: 3'd0, size: 3'd2, source: 2'd2, sink: 1'b0,
                      data: 32'h0, error: 1'b0});
    @(posedge clk_in);
    #1;
    a_valid = 1'b0;
    drain();

    // Streaming: back-to-back Puts then Gets across every word.
    total = 0;
    for (int i = 0; i < 16; i++) begin
      send(PUT_FULL, 3'd2, 2'(i), BASE + 32'(4 * i), 4'hF, 32'(i) * 32'h1111_1111,
           ACK, 32'h0, 1'b0, st);
      total += st;
    end
    for (int i = 0; i < 16; i++) begin
      send(GET, 3'd2, 2'(i), BASE + 32'(4 * i), 4'hF, 32'h0,
           ACK_D, 32'(i) * 32'h1111_1111, 1'b0, st);
      total += st;
    end
    check("stream_stalls", 64'(total), 64'd0);
    drain();

    // Reset with two responses queued.
    d_ready = 1'b0;
    send(GET, 3'd2, 2'd1, BASE + 32'h4, 4'hF, 32'h0, ACK_D, 32'h1111_1111, 1'b0, st);
    send(GET, 3'd2, 2'd2, BASE + 32'h8, 4'hF, 32'h0, ACK_D, 32'h2222_2222, 1'b0, st);
    check("queued_before_reset", d_valid, 1);
    #2;
    reset_in = 1'b1;
    #1;
    check("async_rst_d_valid", d_valid, 0);
    check("async_rst_a_ready", a_ready, 1);
    check("async_rst_d_data",  d_data,  0);
    exp_q.delete();
    @(negedge clk_in);
    reset_in = 1'b0;
    d_ready  = 1'b1;
    @(posedge clk_in);
    #1;
    send(GET, 3'd2, 2'd3, BASE + 32'h4, 4'hF, 32'h0, ACK_D, 32'h0, 1'b0, st);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
